start_initiator: RTL and testbench

- Initiator side of the start/busy/readyS handshake owned by cale_de_control.
- Accepts operand requests from an upstream source and issues a one-cycle start with a stable operand.
- Tracks busy/readyS, captures the result when readyS arrives and offers it downstream on a valid/ready interface.
- Watchdog timeout aborts a transaction when the control path never responds.

---
 rtl/start_initiator_pkg.sv | 21 ++
 rtl/start_initiator_if.sv | 43 ++++
 rtl/start_initiator_watchdog_counter.sv | 32 +++
 rtl/start_initiator.sv | 116 +++++++++++
 tb/tb_start_initiator.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/start_initiator_pkg.sv
// Shared constants for the start/busy/readyS initiator: state encodings,
// default widths and the watchdog counter sizing helper.
package start_initiator_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_ISSUE     = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT_BUSY = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN       = 3'd3;
    localparam logic [STATE_W-1:0] S_HOLD      = 3'd4;

    localparam int DEFAULT_X       = 8;
    localparam int DEFAULT_TIMEOUT = 64;

    // Counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/start_initiator_if.sv
// Request, control-path and result handshakes of the initiator in one bundle.
// master is the initiator's view; slave is the view of everything around it.
interface start_initiator_if
    import start_initiator_pkg::*;
#(
    parameter int x = DEFAULT_X
);
    logic         req_valid;
    logic [x-1:0] req_data;
    logic         req_ready;

    logic         start;
    logic [x-1:0] operand;
    logic         busy;
    logic         readyS;
    logic [x-1:0] result_in;

    logic         res_valid;
    logic [x-1:0] res_data;
    logic         res_ready;

    logic         timeout_err;

    modport master (
        input  req_valid, req_data,
        output req_ready,
        output start, operand,
        input  busy, readyS, result_in,
        output res_valid, res_data,
        input  res_ready,
        output timeout_err
    );

    modport slave (
        output req_valid, req_data,
        input  req_ready,
        input  start, operand,
        output busy, readyS, result_in,
        input  res_valid, res_data,
        output res_ready,
        input  timeout_err
    );
endinterface

// File: rtl/start_initiator_watchdog_counter.sv
// Watchdog for the initiator: counts waiting cycles and flags expiry at
// TIMEOUT-1, so the count is tested before it could ever wrap.
module watchdog_counter
    import start_initiator_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = cnt_width(TIMEOUT);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/start_initiator.sv
// Initiator side of the start/busy/readyS handshake: accepts one operand,
// pulses start, waits for readyS under a watchdog and offers the result.
module start_initiator
    import start_initiator_pkg::*;
#(
    parameter int x       = DEFAULT_X,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    start_initiator_if.master   bus
);
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               wd_clear;
    logic               wd_enable;
    logic               wd_expired;
    logic               accept;
    logic               capture;
    logic               abort;

    watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // NOTE: every signal assigned here gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_clear  = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A result may come back before busy is ever seen.
                if (bus.readyS) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end else if (bus.busy) begin
                    wd_clear  = 1'b1;
                    state_nxt = S_RUN;
                end else if (wd_expired) begin
                    abort     = 1'b1;
                    wd_clear  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            S_RUN: begin
                // busy falling without readyS just keeps us waiting.
                if (bus.readyS) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end else if (wd_expired) begin
                    abort     = 1'b1;
                    wd_clear  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.res_valid && bus.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe and read 0 while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            bus.req_ready   <= 1'b0;
            bus.start       <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.operand     <= '0;
            bus.res_data    <= '0;
        end else begin
            state           <= state_nxt;
            bus.req_ready   <= (state_nxt == S_IDLE);
            bus.start       <= (state_nxt == S_ISSUE);
            bus.res_valid   <= (state_nxt == S_HOLD);
            bus.timeout_err <= abort;
            if (accept) begin
                bus.operand <= bus.req_data;
            end
            if (capture) begin
                bus.res_data <= bus.result_in;
            end
        end
    end

endmodule

// File: tb/tb_start_initiator.sv
// Directed bench for start_initiator with TIMEOUT=8: handshake, fast
// completion, backpressure, watchdog abort, readyS priority and async reset.
module tb_start_initiator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    start_initiator_if #(.x(8)) bus ();

    start_initiator #(
        .x       (8),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.busy      = 1'b0;
        bus.readyS    = 1'b0;
        bus.result_in = 8'h00;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.req_ready, bus.start, bus.res_valid, bus.timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.req_ready, bus.start, bus.res_valid, bus.timeout_err});
        end
        checks++;
        if ({bus.operand, bus.res_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h want 0000", {bus.operand, bus.res_data});
        end
        #2 reset = 1'b0;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_normal();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hA5;
        tick();
        checks++;
        if ({bus.start, bus.req_ready, bus.operand} !== {1'b1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL normal_issue: got start=%b req_ready=%b operand=%h want 1 0 a5",
                     bus.start, bus.req_ready, bus.operand);
        end
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        tick();
        checks++;
        if ({bus.start, bus.operand} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL normal_start_one_cycle: got start=%b operand=%h want 0 a5",
                     bus.start, bus.operand);
        end
        bus.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({bus.start, bus.res_valid, bus.timeout_err, bus.operand} !== {3'b000, 8'hA5}) begin
                errors++;
                $display("FAIL normal_run[%0d]: got start=%b res_valid=%b timeout_err=%b operand=%h want 0 0 0 a5",
                         i, bus.start, bus.res_valid, bus.timeout_err, bus.operand);
            end
        end
        bus.readyS    = 1'b1;
        bus.result_in = 8'h3C;
        tick();
        bus.readyS    = 1'b0;
        bus.busy      = 1'b0;
        bus.result_in = 8'h00;
        checks++;
        if ({bus.res_valid, bus.req_ready, bus.res_data, bus.operand} !== {1'b1, 1'b0, 8'h3C, 8'hA5}) begin
            errors++;
            $display("FAIL normal_result: got res_valid=%b req_ready=%b res_data=%h operand=%h want 1 0 3c a5",
                     bus.res_valid, bus.req_ready, bus.res_data, bus.operand);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.req_ready, bus.res_data} !== {1'b0, 1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL normal_return_idle: got res_valid=%b req_ready=%b res_data=%h want 0 1 3c",
                     bus.res_valid, bus.req_ready, bus.res_data);
        end
    endtask

    task automatic test_fast_completion();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h5A;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.readyS    = 1'b1;
        bus.result_in = 8'h11;
        tick();
        bus.readyS    = 1'b0;
        checks++;
        if ({bus.res_valid, bus.timeout_err, bus.res_data} !== {2'b10, 8'h11}) begin
            errors++;
            $display("FAIL fast_result: got res_valid=%b timeout_err=%b res_data=%h want 1 0 11",
                     bus.res_valid, bus.timeout_err, bus.res_data);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.req_ready, bus.timeout_err} !== 3'b010) begin
            errors++;
            $display("FAIL fast_return_idle: got res_valid=%b req_ready=%b timeout_err=%b want 0 1 0",
                     bus.res_valid, bus.req_ready, bus.timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h66;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.readyS    = 1'b1;
        bus.result_in = 8'h77;
        tick();
        bus.readyS    = 1'b0;
        bus.result_in = 8'h00;
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.res_valid, bus.req_ready, bus.start, bus.res_data, bus.operand}
                    !== {3'b100, 8'h77, 8'h66}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got res_valid=%b req_ready=%b start=%b res_data=%h operand=%h want 1 0 0 77 66",
                         i, bus.res_valid, bus.req_ready, bus.start, bus.res_data, bus.operand);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        checks++;
        if ({bus.res_valid, bus.req_ready, bus.start} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_release: got res_valid=%b req_ready=%b start=%b want 0 1 0",
                     bus.res_valid, bus.req_ready, bus.start);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.start, bus.operand} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL backpressure_next_accept: got start=%b operand=%h want 1 22",
                     bus.start, bus.operand);
        end
        tick();
        bus.readyS    = 1'b1;
        bus.result_in = 8'h23;
        tick();
        bus.readyS    = 1'b0;
        tick();
        checks++;
        if ({bus.req_ready, bus.res_data} !== {1'b1, 8'h23}) begin
            errors++;
            $display("FAIL backpressure_second_result: got req_ready=%b res_data=%h want 1 23",
                     bus.req_ready, bus.res_data);
        end
    endtask

    task automatic test_watchdog();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h0F;
        tick();
        bus.req_valid = 1'b0;
        // Edges E..E+7 after the start cycle: still waiting.
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({bus.timeout_err, bus.res_valid, bus.req_ready} !== 3'b000) begin
                errors++;
                $display("FAIL watchdog_wait[%0d]: got timeout_err=%b res_valid=%b req_ready=%b want 0 0 0",
                         i, bus.timeout_err, bus.res_valid, bus.req_ready);
            end
        end
        tick();
        checks++;
        if ({bus.timeout_err, bus.res_valid, bus.req_ready} !== 3'b101) begin
            errors++;
            $display("FAIL watchdog_abort: got timeout_err=%b res_valid=%b req_ready=%b want 1 0 1",
                     bus.timeout_err, bus.res_valid, bus.req_ready);
        end
        tick();
        checks++;
        if ({bus.timeout_err, bus.operand} !== {1'b0, 8'h0F}) begin
            errors++;
            $display("FAIL watchdog_single_pulse: got timeout_err=%b operand=%h want 0 0f",
                     bus.timeout_err, bus.operand);
        end
    endtask

    task automatic test_priority();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h44;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.busy = 1'b1;
        tick();
        bus.busy = 1'b0;
        // RUN counts 0..6 over these seven edges; the next edge sees cnt==7.
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({bus.timeout_err, bus.res_valid} !== 2'b00) begin
                errors++;
                $display("FAIL priority_run[%0d]: got timeout_err=%b res_valid=%b want 0 0",
                         i, bus.timeout_err, bus.res_valid);
            end
        end
        bus.readyS    = 1'b1;
        bus.result_in = 8'h99;
        tick();
        bus.readyS    = 1'b0;
        checks++;
        if ({bus.res_valid, bus.timeout_err, bus.res_data} !== {2'b10, 8'h99}) begin
            errors++;
            $display("FAIL priority_capture: got res_valid=%b timeout_err=%b res_data=%h want 1 0 99",
                     bus.res_valid, bus.timeout_err, bus.res_data);
        end
        tick();
        checks++;
        if ({bus.timeout_err, bus.res_valid, bus.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL priority_after: got timeout_err=%b res_valid=%b req_ready=%b want 0 0 1",
                     bus.timeout_err, bus.res_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hC3;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.busy = 1'b1;
        tick();
        checks++;
        if (bus.operand !== 8'hC3) begin
            errors++;
            $display("FAIL midrun_operand: got %h want c3", bus.operand);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.start, bus.req_ready, bus.res_valid, bus.timeout_err, bus.operand}
                !== {4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL midrun_async_reset: got start=%b req_ready=%b res_valid=%b timeout_err=%b operand=%h want 0 0 0 0 00",
                     bus.start, bus.req_ready, bus.res_valid, bus.timeout_err, bus.operand);
        end
        #3 reset = 1'b0;
        bus.busy = 1'b0;
        tick();
        checks++;
        if ({bus.req_ready, bus.timeout_err, bus.start} !== 3'b100) begin
            errors++;
            $display("FAIL midrun_release: got req_ready=%b timeout_err=%b start=%b want 1 0 0",
                     bus.req_ready, bus.timeout_err, bus.start);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal();
        test_fast_completion();
        test_back_to_back();
        test_watchdog();
        test_priority();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
